// File: rtl/sram_apb_pkg.sv
// Shared APB/SRAM definitions used by the APB master and the APB SRAM config slave.
//   apb_mst_state_t : APB master FSM state encoding
//   ApbAddrShift    : byte-address shift that turns an SRAM word address into PADDR
package sram_apb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } apb_mst_state_t;

  localparam int unsigned ApbAddrShift = 2;

endpackage

// File: rtl/sram_apb_master.sv
// Bridges a simple valid/ready SRAM command/response interface onto an APB master port.
// Ports:
//   PCLK, PRESETn                      : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                : command handshake (ready only while idle)
//   cmd_write, cmd_addr, cmd_wdata     : command payload (word address, DW-bit data)
//   rsp_valid/rsp_ready                : response handshake
//   rsp_rdata, rsp_err                 : read data (0 for writes/errors), slave error or timeout
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PRDATA, PREADY, PSLVERR : APB master signals
module sram_apb_master
  import sram_apb_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 23,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [31:0]   PADDR,
  output logic [31:0]   PWDATA,
  input  logic [31:0]   PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  apb_mst_state_t state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [31:0]     paddr_q, paddr_d;
  logic [31:0]     pwdata_q, pwdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  // Only PRDATA[DW-1:0] carries SRAM data; the upper bits are ignored.
  logic unused_prdata;
  assign unused_prdata = ^PRDATA;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d    = StSetup;
          wait_cnt_d = '0;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          pwrite_d   = cmd_write;
          paddr_d    = 32'(cmd_addr) << ApbAddrShift;
          pwdata_d   = 32'(cmd_wdata);
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
      end
      StAccess: begin
        if (PREADY) begin
          state_d     = StResp;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          // Writes and slave errors return zero data.
          rsp_rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA[DW-1:0] : '0;
        end else if (wait_cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d     = StResp;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
